fetch_unit: RTL and testbench

Instruction fetch sequencer that drives the load side of the instruction register. Reads 16-bit words from instruction memory over a request/ready handshake, presents each word on `ir_d` with a one-cycle `ir_en` load pulse, then holds until the core releases it. It owns the fetch program counter and supports jump redirects and a memory-timeout fault.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads 16-bit words from instruction memory,
// presents each on ir_d with a one-cycle ir_en load pulse, then holds the
// word until the core releases it with go (optionally redirecting via jmp).
// A memory that stalls for TIMEOUT consecutive FETCH cycles parks the unit
// in ERR with a sticky fault until reset.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(16'h0000),
    parameter int unsigned        TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,

    // instruction memory read port
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [15:0]       mem_data,

    // instruction register load side
    output logic              ir_en,
    output logic [15:0]       ir_d,
    output logic [ADDR_W-1:0] pc,

    // core handshake
    input  logic              go,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,

    // status
    output logic              busy,
    output logic              fault
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WCNT_W = 8;

    // wait count value on the last tolerated stalled FETCH cycle
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fpc_q,   fpc_d;
    logic [WCNT_W-1:0]   wcnt_q,  wcnt_d;
    logic [DATA_W-1:0]   ir_d_q,  ir_d_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;
    logic                fault_q, fault_d;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            wcnt_q  <= '0;
            ir_d_q  <= '0;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            wcnt_q  <= wcnt_d;
            ir_d_q  <= ir_d_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        wcnt_d  = wcnt_q;
        ir_d_d  = ir_d_q;
        pc_d    = pc_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (mem_rdy) begin
                    // a ready word wins over a timeout in the same cycle
                    ir_d_d  = mem_data;
                    pc_d    = fpc_q;
                    fpc_d   = fpc_q + ADDR_W'(1);
                    wcnt_d  = '0;
                    state_d = S_LOAD;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WCNT_LAST) begin
                        fault_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_LOAD: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (go) begin
                    if (jmp) begin
                        fpc_d = jmp_addr;
                    end
                    state_d = S_FETCH;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake outputs and registered data outputs
    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = fpc_q;
    assign ir_en    = (state_q == S_LOAD);
    assign busy     = (state_q != S_HOLD);
    assign ir_d     = ir_d_q;
    assign pc       = pc_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with TIMEOUT=4 / RESET_PC=0
// for the main scenarios, and one with RESET_PC=16'hFFFF for wrap-around.
module tb_fetch_unit;

    logic        clk;

    // main instance signals
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_data;
    logic        ir_en;
    logic [15:0] ir_d;
    logic [15:0] pc;
    logic        go;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic        busy;
    logic        fault;

    // wrap-around instance signals
    logic        rst_w;
    logic        mem_req_w;
    logic [15:0] mem_addr_w;
    logic        mem_rdy_w;
    logic [15:0] mem_data_w;
    logic        ir_en_w;
    logic [15:0] ir_d_w;
    logic [15:0] pc_w;
    logic        go_w;
    logic        jmp_w;
    logic [15:0] jmp_addr_w;
    logic        busy_w;
    logic        fault_w;

    logic [15:0] mem [0:255];

    int n_total;
    int n_bad;

    assign mem_data   = mem[mem_addr[7:0]];
    assign mem_data_w = mem[mem_addr_w[7:0]];

    fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .ir_en    (ir_en),
        .ir_d     (ir_d),
        .pc       (pc),
        .go       (go),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .busy     (busy),
        .fault    (fault)
    );

    fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'hFFFF),
        .TIMEOUT  (15)
    ) u_wrap (
        .clk      (clk),
        .rst      (rst_w),
        .mem_req  (mem_req_w),
        .mem_addr (mem_addr_w),
        .mem_rdy  (mem_rdy_w),
        .mem_data (mem_data_w),
        .ir_en    (ir_en_w),
        .ir_d     (ir_d_w),
        .pc       (pc_w),
        .go       (go_w),
        .jmp      (jmp_w),
        .jmp_addr (jmp_addr_w),
        .busy     (busy_w),
        .fault    (fault_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // compare one observed value with its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to the middle of the next cycle
    task automatic step();
        @(negedge clk);
    endtask

    // main instance must show its reset outputs
    task automatic chk_rst(input string pfx);
        chk({pfx, ".mem_req"},  32'(mem_req),  32'd0);
        chk({pfx, ".mem_addr"}, 32'(mem_addr), 32'h0000);
        chk({pfx, ".ir_en"},    32'(ir_en),    32'd0);
        chk({pfx, ".ir_d"},     32'(ir_d),     32'h0000);
        chk({pfx, ".pc"},       32'(pc),       32'h0000);
        chk({pfx, ".busy"},     32'(busy),     32'd1);
        chk({pfx, ".fault"},    32'(fault),    32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0]   = 16'h00FF;
        mem[1]   = 16'h1234;
        mem[2]   = 16'hBEEF;
        mem[255] = 16'hCAFE;

        rst = 1'b1; go = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000; mem_rdy = 1'b1;
        rst_w = 1'b1; go_w = 1'b0; jmp_w = 1'b0; jmp_addr_w = 16'h0000; mem_rdy_w = 1'b1;

        // reset for two cycles, then sequential zero-wait fetches
        step(); step();
        chk_rst("rst0");
        rst = 1'b0;
        step();
        chk("seq0.fetch.mem_req",  32'(mem_req),  32'd1);
        chk("seq0.fetch.mem_addr", 32'(mem_addr), 32'h0000);
        chk("seq0.fetch.ir_en",    32'(ir_en),    32'd0);
        step();
        chk("seq0.load.ir_en",   32'(ir_en),   32'd1);
        chk("seq0.load.ir_d",    32'(ir_d),    32'h00FF);
        chk("seq0.load.pc",      32'(pc),      32'h0000);
        chk("seq0.load.mem_req", 32'(mem_req), 32'd0);
        chk("seq0.load.busy",    32'(busy),    32'd1);
        step();
        chk("seq0.hold.busy",  32'(busy),  32'd0);
        chk("seq0.hold.ir_en", 32'(ir_en), 32'd0);
        step();
        chk("seq0.hold2.busy", 32'(busy), 32'd0);
        chk("seq0.hold2.ir_d", 32'(ir_d), 32'h00FF);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("seq1.fetch.mem_req",  32'(mem_req),  32'd1);
        chk("seq1.fetch.mem_addr", 32'(mem_addr), 32'h0001);
        chk("seq1.fetch.busy",     32'(busy),     32'd1);
        step();
        chk("seq1.load.ir_en", 32'(ir_en), 32'd1);
        chk("seq1.load.ir_d",  32'(ir_d),  32'h1234);
        chk("seq1.load.pc",    32'(pc),    32'h0001);
        step();
        chk("seq1.hold.busy", 32'(busy), 32'd0);

        // three wait states; ready on the 4th FETCH cycle is also the timeout boundary
        mem_rdy = 1'b0;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wait.c%0d.mem_req", c),  32'(mem_req),  32'd1);
            chk($sformatf("wait.c%0d.mem_addr", c), 32'(mem_addr), 32'h0002);
            chk($sformatf("wait.c%0d.ir_en", c),    32'(ir_en),    32'd0);
            if (c == 4) mem_rdy = 1'b1;
            else step();
        end
        step();
        chk("wait.load.ir_en", 32'(ir_en), 32'd1);
        chk("wait.load.ir_d",  32'(ir_d),  32'hBEEF);
        chk("wait.load.pc",    32'(pc),    32'h0002);
        chk("wait.load.fault", 32'(fault), 32'd0);
        step();

        // jmp without go is ignored
        jmp = 1'b1; jmp_addr = 16'h0040;
        step();
        jmp = 1'b0;
        chk("nojmp.busy",     32'(busy),     32'd0);
        chk("nojmp.pc",       32'(pc),       32'h0002);
        chk("nojmp.mem_addr", 32'(mem_addr), 32'h0003);

        // jump redirect then sequential continuation
        go = 1'b1; jmp = 1'b1; jmp_addr = 16'h0040;
        step();
        go = 1'b0; jmp = 1'b0;
        chk("jmp.fetch.mem_addr", 32'(mem_addr), 32'h0040);
        step();
        chk("jmp.load.ir_d", 32'(ir_d), 32'hA040);
        chk("jmp.load.pc",   32'(pc),   32'h0040);
        step();
        go = 1'b1;
        step();
        go = 1'b0;
        chk("jseq.fetch.mem_addr", 32'(mem_addr), 32'h0041);
        step();
        chk("jseq.load.ir_d", 32'(ir_d), 32'hA041);
        chk("jseq.load.pc",   32'(pc),   32'h0041);
        step();

        // jump to the current pc refetches the same word
        go = 1'b1; jmp = 1'b1; jmp_addr = 16'h0041;
        step();
        go = 1'b0; jmp = 1'b0;
        chk("same.fetch.mem_addr", 32'(mem_addr), 32'h0041);
        step();
        chk("same.load.ir_en", 32'(ir_en), 32'd1);
        chk("same.load.pc",    32'(pc),    32'h0041);
        step();

        // timeout: four stalled FETCH cycles raise fault
        mem_rdy = 1'b0;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("tmo.c%0d.mem_req", c), 32'(mem_req), 32'd1);
            chk($sformatf("tmo.c%0d.fault", c),   32'(fault),   32'd0);
            step();
        end
        chk("tmo.err.fault",   32'(fault),   32'd1);
        chk("tmo.err.mem_req", 32'(mem_req), 32'd0);
        chk("tmo.err.busy",    32'(busy),    32'd1);
        go = 1'b1; jmp = 1'b1; mem_rdy = 1'b1;
        step(); step();
        go = 1'b0; jmp = 1'b0;
        chk("tmo.stick.fault",   32'(fault),   32'd1);
        chk("tmo.stick.mem_req", 32'(mem_req), 32'd0);
        chk("tmo.stick.ir_en",   32'(ir_en),   32'd0);
        chk("tmo.stick.ir_d",    32'(ir_d),    32'hA041);
        rst = 1'b1;
        step();
        chk_rst("rst_err");

        // reset mid-fetch with a stalled memory, late ready ignored
        rst = 1'b0; mem_rdy = 1'b0;
        step();
        chk("mid.fetch.mem_req",  32'(mem_req),  32'd1);
        chk("mid.fetch.mem_addr", 32'(mem_addr), 32'h0000);
        step();
        rst = 1'b1; mem_rdy = 1'b1;
        step();
        chk_rst("rst_mid");
        rst = 1'b0;
        step();
        chk("mid.re.mem_req",  32'(mem_req),  32'd1);
        chk("mid.re.mem_addr", 32'(mem_addr), 32'h0000);
        chk("mid.re.ir_en",    32'(ir_en),    32'd0);
        step();
        chk("mid.re.load.ir_en", 32'(ir_en), 32'd1);
        chk("mid.re.load.ir_d",  32'(ir_d),  32'h00FF);
        chk("mid.re.load.pc",    32'(pc),    32'h0000);

        // wrap-around instance
        chk("wrap.rst.mem_addr", 32'(mem_addr_w), 32'hFFFF);
        chk("wrap.rst.pc",       32'(pc_w),       32'hFFFF);
        chk("wrap.rst.ir_d",     32'(ir_d_w),     32'h0000);
        chk("wrap.rst.fault",    32'(fault_w),    32'd0);
        rst_w = 1'b0;
        step();
        chk("wrap.fetch.mem_req",  32'(mem_req_w),  32'd1);
        chk("wrap.fetch.mem_addr", 32'(mem_addr_w), 32'hFFFF);
        step();
        chk("wrap.load.ir_en", 32'(ir_en_w), 32'd1);
        chk("wrap.load.ir_d",  32'(ir_d_w),  32'hCAFE);
        chk("wrap.load.pc",    32'(pc_w),    32'hFFFF);
        step();
        chk("wrap.hold.busy",     32'(busy_w),     32'd0);
        chk("wrap.hold.mem_addr", 32'(mem_addr_w), 32'h0000);
        go_w = 1'b1;
        step();
        go_w = 1'b0;
        chk("wrap.fetch2.mem_addr", 32'(mem_addr_w), 32'h0000);
        step();
        chk("wrap.load2.ir_d", 32'(ir_d_w), 32'h00FF);
        chk("wrap.load2.pc",   32'(pc_w),   32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
